// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the single register-file write port between the ALU and
// LSU execution pipes. ALU wins by default. The winner is registered onto the
// write port one cycle after acceptance, and every accepted result produces
// exactly one retire pulse.
//
// Optional feature macro: WB_STARVE_GUARD_EN
//   defined   - a 4-bit starvation counter forces an LSU grant after
//               STARVE_LIMIT consecutive ALU grants while LSU is pending.
//   undefined - strict ALU priority; STARVE_LIMIT is ignored.

module wb_arbiter #(
  parameter int REG_WIDTH    = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic                  alu_reg_wr,
  input  logic [REG_WIDTH-1:0]  alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic                  lsu_reg_wr,
  input  logic [REG_WIDTH-1:0]  lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  wb_wr_en,
  output logic [REG_WIDTH-1:0]  wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  retire_valid,
  output logic                  retire_src
);

  // High when the LSU must win regardless of alu_valid.
  logic force_lsu;

  // Multiplexed payload of whichever source is granted.
  logic                  sel_reg_wr;
  logic [REG_WIDTH-1:0]  sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

`ifdef WB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Consecutive ALU grants taken while an LSU result was waiting.
  logic [3:0] starve_cnt;

  // Saturation is implicit: reaching LIMIT with LSU pending forces an LSU
  // grant, which clears the counter on the next edge.
  assign force_lsu = lsu_valid && (starve_cnt >= LIMIT);

  // Starvation counter: count ALU wins over a pending LSU, clear otherwise.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (lsu_ready || !lsu_valid) begin
      starve_cnt <= '0;
    end else if (alu_ready && starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_lsu = 1'b0;
`endif

  // Grant selection: ALU first, LSU when ALU idle or when the guard forces it.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (rst_n) begin
      if (lsu_valid && (!alu_valid || force_lsu)) begin
        lsu_ready = 1'b1;
      end else if (alu_valid) begin
        alu_ready = 1'b1;
      end
    end
  end

  // Payload mux driven by the grant.
  always_comb begin
    sel_reg_wr = alu_reg_wr;
    sel_rd     = alu_rd;
    sel_data   = alu_data;
    if (lsu_ready) begin
      sel_reg_wr = lsu_reg_wr;
      sel_rd     = lsu_rd;
      sel_data   = lsu_data;
    end
  end

  // Write-port and retire registers; rd/data hold on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_wr_en     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      retire_valid <= 1'b0;
      retire_src   <= 1'b0;
    end else if (alu_ready || lsu_ready) begin
      // x0 is hard-wired to zero, so writes to it are suppressed but the
      // transaction still retires.
      wb_wr_en     <= sel_reg_wr && (sel_rd != '0);
      wb_rd        <= sel_rd;
      wb_data      <= sel_data;
      retire_valid <= 1'b1;
      retire_src   <= lsu_ready;
    end else begin
      wb_wr_en     <= 1'b0;
      retire_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized stimulus for wb_arbiter, checked
// against a behavioural reference model of the arbitration rules.
// Honors WB_STARVE_GUARD_EN the same way the design does.

module tb_wb_arbiter;

  localparam int RW    = 5;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, alu_ready, alu_reg_wr;
  logic [RW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          lsu_valid, lsu_ready, lsu_reg_wr;
  logic [RW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          wb_wr_en;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          retire_valid, retire_src;

  wb_arbiter #(.REG_WIDTH(RW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_reg_wr   (alu_reg_wr),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_reg_wr   (lsu_reg_wr),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .wb_wr_en     (wb_wr_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .retire_valid (retire_valid),
    .retire_src   (retire_src)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: how long the LSU has been passed over, and the
  // values the write port is expected to show.
  int            lsu_waited = 0;
  logic          exp_wr_en = 1'b0, exp_retire = 1'b0, exp_src = 1'b0;
  logic [RW-1:0] exp_rd = '0;
  logic [DW-1:0] exp_data = '0;

  // Grants the model predicted in the most recent step.
  logic last_alu = 1'b0, last_lsu = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs must already be applied. Predicts the grant from the
  // rules, checks readys mid-cycle, then checks the registered outputs.
  task automatic step(input string tag);
    logic ea, el, starved;
`ifdef WB_STARVE_GUARD_EN
    starved = lsu_valid && (lsu_waited >= LIMIT);
`else
    starved = 1'b0;
`endif
    ea = 1'b0;
    el = 1'b0;
    if (rst_n) begin
      if (lsu_valid && (starved || !alu_valid)) el = 1'b1;
      else if (alu_valid)                       ea = 1'b1;
    end
    @(negedge clk);
    check({tag, ".alu_ready"}, 64'(alu_ready), 64'(ea));
    check({tag, ".lsu_ready"}, 64'(lsu_ready), 64'(el));

    if (!rst_n) begin
      exp_wr_en = 0; exp_rd = '0; exp_data = '0; exp_retire = 0; exp_src = 0;
      lsu_waited = 0;
    end else begin
      if (ea || el) begin
        exp_rd     = el ? lsu_rd : alu_rd;
        exp_data   = el ? lsu_data : alu_data;
        exp_wr_en  = (el ? lsu_reg_wr : alu_reg_wr) && (exp_rd != 0);
        exp_retire = 1'b1;
        exp_src    = el;
      end else begin
        exp_wr_en  = 1'b0;
        exp_retire = 1'b0;
      end
      if (el || !lsu_valid) lsu_waited = 0;
      else if (ea)          lsu_waited = (lsu_waited + 1 > LIMIT) ? LIMIT : lsu_waited + 1;
    end
    last_alu = ea;
    last_lsu = el;

    @(posedge clk);
    #1;
    check({tag, ".wb_wr_en"},     64'(wb_wr_en),     64'(exp_wr_en));
    check({tag, ".wb_rd"},        64'(wb_rd),        64'(exp_rd));
    check({tag, ".wb_data"},      64'(wb_data),      64'(exp_data));
    check({tag, ".retire_valid"}, 64'(retire_valid), 64'(exp_retire));
    if (exp_retire) check({tag, ".retire_src"}, 64'(retire_src), 64'(exp_src));
  endtask

  task automatic new_alu(input logic v);
    alu_valid  = v;
    alu_reg_wr = 1'($urandom_range(0, 1));
    alu_rd     = RW'($urandom);
    alu_data   = $urandom;
  endtask

  task automatic new_lsu(input logic v);
    lsu_valid  = v;
    lsu_reg_wr = 1'($urandom_range(0, 1));
    lsu_rd     = RW'($urandom);
    lsu_data   = $urandom;
  endtask

  initial begin
    int first_lsu;
    int retires;

    // Reset held for 3 cycles with both sources requesting.
    rst_n = 1'b0;
    new_alu(1'b1);
    new_lsu(1'b1);
    for (int i = 0; i < 3; i++) step("reset");
    check("reset.wb_rd_zero",   64'(wb_rd),   64'd0);
    check("reset.wb_data_zero", 64'(wb_data), 64'd0);

    // Single ALU write.
    rst_n = 1'b1;
    alu_valid = 1'b1; alu_reg_wr = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    lsu_valid = 1'b0;
    step("single_alu");
    check("single_alu.data", 64'(wb_data), 64'hDEADBEEF);
    check("single_alu.src",  64'(retire_src), 64'd0);

    // LSU writing x0, then ALU with reg_wr=0: both retire, neither writes.
    alu_valid = 1'b0;
    lsu_valid = 1'b1; lsu_reg_wr = 1'b1; lsu_rd = 0; lsu_data = 32'h1234_5678;
    step("x0_lsu");
    check("x0_lsu.no_write", 64'(wb_wr_en), 64'd0);
    check("x0_lsu.retire",   64'(retire_valid), 64'd1);
    lsu_valid = 1'b0;
    alu_valid = 1'b1; alu_reg_wr = 1'b0; alu_rd = 7; alu_data = 32'hCAFE_F00D;
    step("nowr_alu");
    check("nowr_alu.no_write", 64'(wb_wr_en), 64'd0);
    check("nowr_alu.retire",   64'(retire_valid), 64'd1);

    // Idle cycle: no grant, rd/data hold.
    alu_valid = 1'b0;
    step("idle");

    // Contention: both valid for 10 cycles, fresh ALU payload after each win.
    first_lsu = -1;
    new_alu(1'b1);
    new_lsu(1'b1);
    for (int i = 0; i < 10; i++) begin
      step("contend");
      if (last_lsu && first_lsu < 0) first_lsu = i;
      if (last_alu) new_alu(1'b1);
    end
`ifdef WB_STARVE_GUARD_EN
    check("contend.first_lsu", 64'(first_lsu), 64'(LIMIT));
`else
    check("contend.first_lsu", 64'(first_lsu), 64'(-1));
`endif
    // ALU drops: the pending LSU must win now.
    alu_valid = 1'b0;
    step("contend_drop");
    check("contend_drop.lsu_src", 64'(retire_src), 64'd1);

    // Back-to-back alternating sources: 8 retires on 8 consecutive cycles.
    retires = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        new_alu(1'b1); lsu_valid = 1'b0;
      end else begin
        new_lsu(1'b1); alu_valid = 1'b0;
      end
      step("b2b");
      if (retire_valid) retires++;
      check("b2b.src", 64'(retire_src), 64'(i % 2));
    end
    check("b2b.count", 64'(retires), 64'd8);

    // Randomized traffic obeying the hold-until-accepted rule, with
    // occasional resets that also flush the upstream pipes.
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!rst_n) begin
        rst_n = 1'b1;
        new_alu(1'($urandom_range(0, 1)));
        new_lsu(1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 99) < 2) begin
        rst_n = 1'b0;
      end else begin
        if (last_alu || !alu_valid) new_alu(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0);
        if (last_lsu || !lsu_valid) new_lsu(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
      end
      step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
